ccta: RTL and testbench



---
 rtl/ccta.sv | 84 ++++++++
 tb/tb_ccta.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ccta.sv
// Registered conditional add/subtract stage: saturating A+B+C or clamped (A+B)-C.
// Optional input register stage under CCTA_INREG_EN (latency 2 instead of 1).
module ccta (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic       ctrl,
  output logic [4:0] q
);

  localparam int unsigned OpW  = 4;
  localparam int unsigned SumW = 5;
  localparam int unsigned TotW = 6;
  localparam logic [SumW-1:0] SatMax = '1;

  logic [OpW-1:0]  op_a, op_b, op_c;
  logic            op_ctrl;
  logic [SumW-1:0] sum_c;
  logic [TotW-1:0] total_c;
  logic [SumW-1:0] q_d;
  logic [SumW-1:0] q_q;

`ifdef CCTA_INREG_EN
  logic [OpW-1:0] a_q, b_q, c_q;
  logic           ctrl_q;

  // Input capture stage; clears with the output so no stale operand survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ctrl_q <= 1'b0;
    end else begin
      a_q    <= A;
      b_q    <= B;
      c_q    <= C;
      ctrl_q <= ctrl;
    end
  end

  assign op_a    = a_q;
  assign op_b    = b_q;
  assign op_c    = c_q;
  assign op_ctrl = ctrl_q;
`else
  assign op_a    = A;
  assign op_b    = B;
  assign op_c    = C;
  assign op_ctrl = ctrl;
`endif

  assign sum_c   = SumW'(op_a) + SumW'(op_b);
  assign total_c = TotW'(sum_c) + TotW'(op_c);

  // Widths are chosen so neither mode can wrap before the saturate/clamp decision.
  always_comb begin
    q_d = '0;
    if (op_ctrl) begin
      if (sum_c >= SumW'(op_c)) begin
        q_d = sum_c - SumW'(op_c);
      end
    end else begin
      if (total_c > TotW'(SatMax)) begin
        q_d = SatMax;
      end else begin
        q_d = total_c[SumW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ccta.sv
// Scoreboard bench for ccta: expected results queued at drive time, popped as q is sampled.
module tb_ccta;

`ifdef CCTA_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] a, b, c;
  logic       ctrl;
  logic [4:0] q;

  int checks;
  int failures;
  logic [4:0] exp_q[$];
  logic [4:0] last_exp;

  ccta dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .C    (c),
    .ctrl (ctrl),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b (%0d) expected %b (%0d) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [4:0] model(input int av, input int bv, input int cv, input logic m);
    int r;
    if (m) begin
      r = av + bv - cv;
      if (r < 0) r = 0;
    end else begin
      r = av + bv + cv;
      if (r > 31) r = 31;
    end
    return 5'(r);
  endfunction

  task automatic prime_queue();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(5'd0);
  endtask

  // Drive one vector, advance one edge, compare the result that emerges.
  task automatic run_vec(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] cv, input logic m);
    logic [4:0] e;
    a = av; b = bv; c = cv; ctrl = m;
    exp_q.push_back(model(int'(av), int'(bv), int'(cv), m));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got %b", tag, q);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check_eq(tag, q, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_exp = '0;
    a = 4'b1010; b = 4'b0110; c = 4'b0001; ctrl = 1'b0;
    rst = 1'b0;

    // Asynchronous reset, away from any edge.
    #2 rst = 1'b1;
    #1 check_eq("rst_async", q, 5'd0);
    repeat (2) @(posedge clk);
    #1 check_eq("rst_hold", q, 5'd0);
    @(negedge clk) rst = 1'b0;
    prime_queue();

    run_vec("sub_clamp10", 4'b1100, 4'b0011, 4'b0101, 1'b1);
    run_vec("add25",       4'b0110, 4'b1001, 4'b1010, 1'b0);
    run_vec("sat45",       4'b1111, 4'b1111, 4'b1111, 1'b0);
    run_vec("clamp_lt",    4'd1,    4'd2,    4'd9,    1'b1);
    run_vec("clamp_eq",    4'd4,    4'd5,    4'd9,    1'b1);
    run_vec("exact31",     4'd15,   4'd15,   4'd1,    1'b0);
    run_vec("sat32",       4'd15,   4'd15,   4'd2,    1'b0);
    run_vec("sub_max",     4'd15,   4'd15,   4'd0,    1'b1);

    // Back-to-back with ctrl alternating against each vector's natural mode.
    for (int r = 0; r < 2; r++) begin
      run_vec("b2b_v0", 4'b1100, 4'b0011, 4'b0101, 1'(r));
      run_vec("b2b_v1", 4'b0110, 4'b1001, 4'b1010, 1'(r + 1));
      run_vec("b2b_v2", 4'b1111, 4'b1111, 4'b1111, 1'(r));
      run_vec("b2b_v3", 4'd1,    4'd2,    4'd9,    1'(r + 1));
    end

    // q must not follow inputs between edges.
    run_vec("pre_glitch", 4'd7, 4'd3, 4'd2, 1'b0);
    a = 4'd0; b = 4'd0; c = 4'd15; ctrl = 1'b1;
    #2 check_eq("no_comb_path", q, last_exp);

    for (int i = 0; i < 40; i++) begin
      run_vec("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset with a nonzero result on q and another in flight.
    run_vec("pre_rst0", 4'd9, 4'd8, 4'd3, 1'b0);
    run_vec("pre_rst1", 4'd6, 4'd6, 4'd1, 1'b1);
    a = 4'd10; b = 4'd10; c = 4'd5; ctrl = 1'b0;
    #2 rst = 1'b1;
    #1 check_eq("rst_mid_async", q, 5'd0);
    repeat (2) @(posedge clk);
    #1 check_eq("rst_mid_hold", q, 5'd0);
    @(negedge clk) rst = 1'b0;
    prime_queue();

    run_vec("post_rst0", 4'd2, 4'd3, 4'd4, 1'b0);
    run_vec("post_rst1", 4'd8, 4'd8, 4'd3, 1'b1);
    run_vec("post_rst2", 4'd0, 4'd0, 4'd0, 1'b0);
    run_vec("post_rst3", 4'd14, 4'd13, 4'd12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
